// File: rtl/mdu_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    localparam logic        OP_MUL    = 1'b0;
    localparam logic        OP_DIV    = 1'b1;
    localparam int          MDU_ITERS = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    // 33-bit magnitude so that |-2^31| stays representable
    function automatic logic [32:0] abs33(input logic [31:0] x);
        return x[31] ? ({1'b0, ~x} + 33'd1) : {1'b0, x};
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Bus-side handshake between the control unit (master) and the multiply/divide unit (slave).
interface mul_div_unit_if #(parameter int WIDTH = 32);

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             hi_load;
    logic             lo_load;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, hi_load, lo_load, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, hi_load, lo_load, div_by_zero
    );

endinterface

// File: rtl/mdu_iter_step.sv
// One iteration of the datapath: Booth add/sub + arithmetic shift, or restoring trial subtract + shift.
module mdu_iter_step
    import mdu_pkg::*;
(
    input  logic        i_op,
    input  logic [64:0] i_work,
    input  logic [32:0] i_m,
    output logic [64:0] o_work
);

    logic [32:0] w_acc;
    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic [33:0] w_diff;

    always_comb begin
        o_work = i_work;
        // MUL view: {acc[31:0], multiplier[31:0], q-1}; acc widened so the add cannot wrap
        w_acc = {i_work[64], i_work[64:33]};
        case (i_work[1:0])
            2'b01:   w_sum = w_acc + i_m;
            2'b10:   w_sum = w_acc - i_m;
            default: w_sum = w_acc;
        endcase
        // DIV view: {rem[32:0], quot[31:0]}
        w_shift = {i_work[63:32], i_work[31]};
        w_diff  = {1'b0, w_shift} - {1'b0, i_m};
        if (i_op == OP_MUL) begin
            o_work = {w_sum[32:1], w_sum[0], i_work[32:2], i_work[1]};
        end else if (!w_diff[33]) begin
            o_work = {w_diff[32:0], i_work[30:0], 1'b1};
        end else begin
            o_work = {w_shift, i_work[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Sequential signed 32x32 multiply / divide, one bit per clock, results into HI/LO.
//   state | meaning
//   IDLE  | waiting for start; divide-by-zero resolved here directly
//   CALC  | one Booth / restoring-divide iteration per cycle, 32 cycles
//   ADJ   | sign fix-up for DIV, results registered into hi/lo
//   DONE  | one cycle; done/hi_load/lo_load pulse on the following cycle
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITERS
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);

    localparam logic [4:0] CNT_LOAD = 5'(WIDTH - 1);

    mdu_state_e  r_state;
    mdu_state_e  w_state_nxt;
    logic [4:0]  r_cnt;
    logic        r_op;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic [64:0] r_work;
    logic [64:0] w_work_nxt;
    logic [32:0] r_m;
    logic        w_div0;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    mdu_iter_step u_step (
        .i_op   (r_op),
        .i_work (r_work),
        .i_m    (r_m),
        .o_work (w_work_nxt)
    );

    always_comb begin
        w_div0      = bus.start && (bus.op == OP_DIV) && (bus.b == '0);
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = w_div0 ? DONE : CALC;
            CALC:    if (r_cnt == '0) w_state_nxt = ADJ;
            ADJ:     w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_quot   = r_work[31:0];
        w_rem    = r_work[63:32];
        w_res_hi = r_work[64:33];
        w_res_lo = r_work[32:1];
        if (r_op == OP_DIV) begin
            w_res_lo = r_neg_q ? -w_quot : w_quot;
            w_res_hi = r_neg_r ? -w_rem : w_rem;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Status outputs are registered from the current state, so they trail it by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt           <= '0;
            r_op            <= OP_MUL;
            r_neg_q         <= 1'b0;
            r_neg_r         <= 1'b0;
            r_dz            <= 1'b0;
            r_work          <= '0;
            r_m             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.hi_load     <= 1'b0;
            bus.lo_load     <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
        end else begin
            bus.busy        <= (r_state == CALC) || (r_state == ADJ);
            bus.done        <= (r_state == DONE);
            bus.hi_load     <= (r_state == DONE);
            bus.lo_load     <= (r_state == DONE);
            bus.div_by_zero <= (r_state == DONE) && r_dz;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_cnt   <= CNT_LOAD;
                        r_neg_q <= bus.a[31] ^ bus.b[31];
                        r_neg_r <= bus.a[31];
                        r_dz    <= w_div0;
                        if (bus.op == OP_DIV) begin
                            r_work <= {32'd0, abs33(bus.a)};
                            r_m    <= abs33(bus.b);
                        end else begin
                            r_work <= {32'd0, bus.b, 1'b0};
                            r_m    <= {bus.a[31], bus.a};
                        end
                        if (w_div0) begin
                            bus.hi <= bus.a;
                            bus.lo <= DIV0_QUOT;
                        end
                    end
                end
                CALC: begin
                    r_work <= w_work_nxt;
                    if (r_cnt != '0) r_cnt <= r_cnt - 5'd1;
                end
                ADJ: begin
                    bus.hi <= w_res_hi;
                    bus.lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Sequential signed 32×32 multiply / divide unit for the Mini SRC datapath. It takes two 32-bit operands from the bus side and iterates one bit per clock. It then presents a 64-bit result as `hi`/`lo` with one-cycle `hi_load`/`lo_load` strobes. Those strobes directly drive the load inputs of the HI and LO 32-bit registers downstream. The control unit starts an operation and stalls on `busy` until `done`.

## Interface
- `WIDTH`, 32, operand width. Only 32 is supported. The iteration count equals `WIDTH`.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = multiply (MUL), 1 = divide (DIV); captured with `start`.
- `a`  in  32  multiplicand / dividend (signed); captured with `start`.
- `b`  in  32  multiplier / divisor (signed); captured with `start`.
- `busy`  out  1  high in CALC and ADJ.
- `done`  out  1  one-cycle pulse in DONE.
- `hi`  out  32  MUL: product[63:32]; DIV: remainder.
- `lo`  out  32  MUL: product[31:0]; DIV: quotient.
- `hi_load`, `lo_load`  out  1 each  equal to `done`; drive the HI and LO register `load` inputs.
- `div_by_zero`  out  1  valid with `done`; high only for DIV with `b == 0`.

## Operation
- **States:** IDLE, CALC, ADJ, DONE.
- **IDLE:**
  - On `start` = 1, capture `op`, `a` and `b`, and load the iteration counter with 31.
  - If DIV and `b == 0`, go to DONE. Otherwise go to CALC.
- **CALC:** one iteration per cycle. When the counter reaches 0, go to ADJ; otherwise decrement it.
  - MUL uses radix-2 Booth on a 65-bit {acc, multiplier, q-1} register with arithmetic shift right.
  - DIV uses restoring division on the magnitudes |a| and |b|, producing one quotient bit per cycle.
- **ADJ:** one cycle.
  - MUL: no change.
  - DIV: negate the quotient if the signs of `a` and `b` differ. Negate the remainder if `a` < 0. This gives C semantics: truncate toward zero, remainder takes the sign of the dividend.
  - Register the results into `hi`/`lo`, then go to DONE.
- **DONE:** assert `done`, `hi_load` and `lo_load` for one cycle, then go to IDLE.
- **Divide-by-zero result:** `hi` = `a`, `lo` = 0xFFFF_FFFF, `div_by_zero` = 1.
- **Overflow case:** DIV 0x8000_0000 / 0xFFFF_FFFF wraps. Result: `lo` = 0x8000_0000, `hi` = 0, `div_by_zero` = 0. Magnitudes are computed in 33 bits internally so |−2^31| is representable.
- **Ignored `start`:** `start` is ignored in CALC, ADJ and DONE. An operation in flight cannot be restarted or aborted except by `reset`.
- **Output hold:** `hi`/`lo` change only on the ADJ→DONE transition or the divide-by-zero IDLE→DONE transition, and otherwise hold the last result.

## Timing
- **Reset values:**
  - State = IDLE.
  - `busy`, `done`, `hi_load`, `lo_load`, `div_by_zero` = 0.
  - `hi`, `lo` = 0.
  - Counter = 0.
  - Reset is asynchronous and takes effect mid-operation with no pending result.
- **Normal latency:** `start` is sampled at edge N.
  - `busy` is high after edges N+1 … N+33.
  - `done` is high for the single cycle after edge N+34.
  - `hi`/`lo` are valid from edge N+34 onward.
- **Divide-by-zero latency:** `done` is high after edge N+1. `busy` never rises.
- **Back-to-back starts:** a new `start` is accepted no earlier than the edge after DONE. Minimum issue interval is 35 cycles.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Structure
- **Package `mdu_pkg`:**
  - state enum (IDLE, CALC, ADJ, DONE);
  - op encoding constants `OP_MUL` = 1'b0 and `OP_DIV` = 1'b1;
  - `MDU_ITERS` = 32;
  - the divide-by-zero quotient constant 32'hFFFF_FFFF.
- **Sub-module `mdu_iter_step`:** combinational single-iteration logic.
  - MUL: Booth add/sub/none plus arithmetic shift.
  - DIV: trial subtract plus shift.
  - Instantiated once. The top level holds the FSM, counter and registers.

## Test plan
- **MUL 7 × −3** (`a` = 0x0000_0007, `b` = 0xFFFF_FFFD) → `hi` = 0xFFFF_FFFF, `lo` = 0xFFFF_FFEB. `done`, `hi_load` and `lo_load` pulse exactly 34 edges after `start`.
- **MUL 0x8000_0000 × 0x8000_0000** → `hi` = 0x4000_0000, `lo` = 0x0000_0000. `div_by_zero` = 0.
- **DIV −7 / 2** → `lo` = 0xFFFF_FFFD (−3), `hi` = 0xFFFF_FFFF (−1). **DIV 7 / −2** → `lo` = 0xFFFF_FFFD, `hi` = 0x0000_0001.
- **DIV 5 / 0** → `done` one edge after `start`, `div_by_zero` = 1, `hi` = 0x0000_0005, `lo` = 0xFFFF_FFFF, `busy` never high.
- **DIV 0x8000_0000 / 0xFFFF_FFFF** → `lo` = 0x8000_0000, `hi` = 0. In the same run, `start` held high during CALC with different operands is ignored and the result is unchanged.
- **Reset asserted** at the 10th CALC cycle of a MUL → immediately `busy` = 0, `done` = 0, `hi` = `lo` = 0. No `done` pulse follows. A fresh MUL 3 × 4 then yields `lo` = 0x0000_000C, `hi` = 0.
